// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle between requesters, the shared FastMult datapath and the
// response consumer of mult_share_arbiter.
interface mult_share_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = 2
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_lhs;
  logic [N*W-1:0] req_rhs;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   mul_lhs;
  logic [W-1:0]   mul_rhs;
  logic [2*W-1:0] mul_out;
  logic           resp_valid;
  logic [IW-1:0]  resp_id;
  logic [2*W-1:0] resp_data;
  logic           resp_ready;

  modport master (
    output req_valid, req_lhs, req_rhs, mul_out, resp_ready,
    input  req_ready, mul_lhs, mul_rhs, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_lhs, req_rhs, mul_out, resp_ready,
    output req_ready, mul_lhs, mul_rhs, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one external combinational multiplier between N
// requesters; one transaction in flight, product returned with requester id.
module mult_share_arbiter #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = 2
) (
  input logic               clk,
  input logic               reset,
  mult_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  grant;
  logic           any_valid;
  logic           upper_hit;
  logic [W-1:0]   op_lhs;
  logic [W-1:0]   op_rhs;
  logic [2*W-1:0] resp_data;
  logic [IW-1:0]  resp_id;
  logic           resp_valid;

  // Wrap-around search in two passes: a valid requester above last_grant
  // wins, otherwise the lowest-indexed valid requester.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    upper_hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_valid && bus.req_valid[i]) begin
        any_valid = 1'b1;
        grant     = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!upper_hit && bus.req_valid[i] && (IW'(i) > last_grant)) begin
        upper_hit = 1'b1;
        grant     = IW'(i);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && any_valid && !reset)
      bus.req_ready = {{(N-1){1'b0}}, 1'b1} << grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(N-1);
      op_lhs     <= '0;
      op_rhs     <= '0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_lhs     <= bus.req_lhs[grant*W +: W];
            op_rhs     <= bus.req_rhs[grant*W +: W];
            resp_id    <= grant;
            last_grant <= grant;
            state      <= CALC;
          end
        end
        CALC: begin
          resp_data  <= bus.mul_out;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_lhs    = op_lhs;
  assign bus.mul_rhs    = op_rhs;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_id    = resp_id;
  assign bus.resp_data  = resp_data;
endmodule
